// File: rtl/serial_tx.sv
`timescale 1ns/1ps
// Purpose    : framed bit-serial transmitter (start, data LSB-first, optional parity, stop bits).
// Latency    : start bit appears on tx the cycle after accept; frame = (1+size+PARITY_EN+STOP_BITS)*DIV cycles.
// Backpressure: ready_out is high only in IDLE; valid_in is ignored while a frame is in flight.
//
// Ports:
//   clk       - clock, all state changes on posedge
//   rst       - asynchronous active-high reset; aborts any frame in progress
//   data_in   - word to transmit, captured on the accept edge only
//   valid_in  - upstream presents a word on data_in
//   ready_out - transmitter can accept a word this cycle
//   tx        - serial line (registered), idle high
//   busy      - frame in progress (registered), high through the done cycle
//   done      - single-cycle pulse on the final cycle of the last stop bit
module serial_tx #(
    parameter int size       = 8,
    parameter int DIV        = 4,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [size-1:0] data_in,
    input  logic            valid_in,
    output logic            ready_out,
    output logic            tx,
    output logic            busy,
    output logic            done
);

    // Divider and bit counter widths; both are kept at least one bit wide so
    // DIV=1 and size=1 configurations still elaborate cleanly.
    localparam int DW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BMAX = (size > STOP_BITS) ? size : STOP_BITS;
    localparam int BW   = (BMAX > 1) ? $clog2(BMAX) : 1;

    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(size - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic          PAR_INV   = (PARITY_ODD != 0);
    localparam logic          HAS_PAR   = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [size-1:0] shreg;
    logic [size-1:0] shreg_nxt;
    logic [DW-1:0]   div_cnt;
    logic [DW-1:0]   div_nxt;
    logic [BW-1:0]   bit_cnt;
    logic [BW-1:0]   bit_nxt;
    logic            parity;
    logic            parity_nxt;
    logic            tx_nxt;
    logic            busy_nxt;

    logic            accept;
    logic            bit_end;
    logic            data_last;
    logic            stop_last;

    // Handshake: ready is combinational on the state so it drops in the same
    // cycle an asynchronous reset arrives and rises right after release.
    assign ready_out = (state == IDLE) && !rst;
    assign accept    = (state == IDLE) && valid_in && ready_out;

    // The divider runs only while a frame is active; each bit spans DIV cycles.
    assign bit_end   = (div_cnt == DIV_LAST);
    assign data_last = (bit_cnt == DATA_LAST);
    assign stop_last = (bit_cnt == STOP_LAST);

    // ------------------------------------------------------------------
    // State register (plus datapath registers and registered outputs)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            div_cnt <= '0;
            bit_cnt <= '0;
            parity  <= 1'b0;
            tx      <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            div_cnt <= div_nxt;
            bit_cnt <= bit_nxt;
            parity  <= parity_nxt;
            tx      <= tx_nxt;
            busy    <= busy_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (bit_end && data_last) begin
                    state_nxt = HAS_PAR ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (bit_end && stop_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next values: divider, bit counter, shift register, parity
    // ------------------------------------------------------------------
    always_comb begin
        shreg_nxt  = shreg;
        div_nxt    = div_cnt;
        bit_nxt    = bit_cnt;
        parity_nxt = parity;

        if (state == IDLE) begin
            div_nxt = '0;
            bit_nxt = '0;
            if (accept) begin
                shreg_nxt  = data_in;
                // Even parity is the XOR of the data bits; odd is its inverse.
                parity_nxt = (^data_in) ^ PAR_INV;
            end
        end else begin
            div_nxt = bit_end ? '0 : div_cnt + 1'b1;
            if (bit_end) begin
                case (state)
                    DATA: begin
                        shreg_nxt = shreg >> 1;
                        bit_nxt   = data_last ? '0 : bit_cnt + 1'b1;
                    end
                    STOP: begin
                        // The bit counter is reused to count stop bits.
                        bit_nxt = stop_last ? '0 : bit_cnt + 1'b1;
                    end
                    default: begin
                        bit_nxt = '0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Output logic. tx and busy are computed from the next state so the
    // registered copies line up with the state they describe; done is a
    // decode of the current state, which is itself a register.
    // ------------------------------------------------------------------
    always_comb begin
        tx_nxt   = 1'b1;
        busy_nxt = (state_nxt != IDLE);
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shreg_nxt[0];
            PARITY:  tx_nxt = parity_nxt;
            default: tx_nxt = 1'b1;
        endcase
    end

    assign done = (state == STOP) && bit_end && stop_last;

endmodule

// File: tb/tb_serial_tx.sv
`timescale 1ns/1ps
// Bench for serial_tx: four instances cover the base frame, even and odd
// parity, and the DIV=1 / two-stop-bit corner. Expected line values are
// pushed per cycle into a queue and popped as the DUT drives the line.
module tb_serial_tx;

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic [3:0] valid_v;
    wire  [3:0] rdy_v;
    wire  [3:0] tx_v;
    wire  [3:0] busy_v;
    wire  [3:0] done_v;

    int errors;
    int checks;
    logic exp_q[$];

    // 0: base, 1: even parity, 2: odd parity, 3: DIV=1 with two stop bits
    serial_tx #(.size(8), .DIV(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_base (
        .clk(clk), .rst(rst), .data_in(din), .valid_in(valid_v[0]), .ready_out(rdy_v[0]),
        .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]));
    serial_tx #(.size(8), .DIV(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_even (
        .clk(clk), .rst(rst), .data_in(din), .valid_in(valid_v[1]), .ready_out(rdy_v[1]),
        .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]));
    serial_tx #(.size(8), .DIV(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_odd (
        .clk(clk), .rst(rst), .data_in(din), .valid_in(valid_v[2]), .ready_out(rdy_v[2]),
        .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]));
    serial_tx #(.size(8), .DIV(1), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_fast (
        .clk(clk), .rst(rst), .data_in(din), .valid_in(valid_v[3]), .ready_out(rdy_v[3]),
        .tx(tx_v[3]), .busy(busy_v[3]), .done(done_v[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference frame: start 0, data LSB-first, optional parity, stop 1s,
    // each bit repeated div times.
    task automatic push_frame(input logic [7:0] w, input int div, input int pe,
                              input int po, input int stops);
        logic p;
        p = 1'b0;
        for (int b = 0; b < 8; b++) p = p ^ w[b];
        if (po != 0) p = ~p;
        for (int k = 0; k < div; k++) exp_q.push_back(1'b0);
        for (int b = 0; b < 8; b++)
            for (int k = 0; k < div; k++) exp_q.push_back(w[b]);
        if (pe != 0)
            for (int k = 0; k < div; k++) exp_q.push_back(p);
        for (int k = 0; k < stops * div; k++) exp_q.push_back(1'b1);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        din = 8'h00;
        valid_v = 4'b0000;
        #12;
        checks++; if (tx_v !== 4'b1111) begin errors++; $display("FAIL reset_tx got=%b exp=1111", tx_v); end
        checks++; if (busy_v !== 4'b0000) begin errors++; $display("FAIL reset_busy got=%b exp=0000", busy_v); end
        checks++; if (done_v !== 4'b0000) begin errors++; $display("FAIL reset_done got=%b exp=0000", done_v); end
        checks++; if (rdy_v !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b exp=0000", rdy_v); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (rdy_v !== 4'b1111) begin errors++; $display("FAIL reset_release_ready got=%b exp=1111", rdy_v); end
    endtask

    task automatic test_basic;
        int len;
        logic e;
        @(negedge clk);
        checks++; if (rdy_v[0] !== 1'b1) begin errors++; $display("FAIL basic_ready_pre got=%b exp=1", rdy_v[0]); end
        din = 8'hA5; valid_v[0] = 1'b1;
        push_frame(8'hA5, 4, 0, 0, 1);
        len = exp_q.size();
        for (int c = 1; c <= len; c++) begin
            @(negedge clk);
            valid_v[0] = 1'b0;
            e = exp_q.pop_front();
            checks++; if (tx_v[0] !== e) begin errors++; $display("FAIL basic_tx cycle=%0d got=%b exp=%b", c, tx_v[0], e); end
            checks++; if (done_v[0] !== (c == 40)) begin errors++; $display("FAIL basic_done cycle=%0d got=%b exp=%b", c, done_v[0], (c == 40)); end
            checks++; if (busy_v[0] !== 1'b1) begin errors++; $display("FAIL basic_busy cycle=%0d got=%b exp=1", c, busy_v[0]); end
            checks++; if (rdy_v[0] !== 1'b0) begin errors++; $display("FAIL basic_ready cycle=%0d got=%b exp=0", c, rdy_v[0]); end
        end
        @(negedge clk);
        checks++; if ({tx_v[0], busy_v[0], rdy_v[0], done_v[0]} !== 4'b1010) begin
            errors++; $display("FAIL basic_idle got=%b exp=1010", {tx_v[0], busy_v[0], rdy_v[0], done_v[0]}); end
    endtask

    task automatic test_parity;
        int len;
        logic e;
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk);
            checks++; if (rdy_v[i] !== 1'b1) begin errors++; $display("FAIL parity_ready_pre inst=%0d got=%b exp=1", i, rdy_v[i]); end
            din = 8'h07; valid_v[i] = 1'b1;
            push_frame(8'h07, 4, 1, i - 1, 1);
            len = exp_q.size();
            for (int c = 1; c <= len; c++) begin
                @(negedge clk);
                valid_v[i] = 1'b0;
                e = exp_q.pop_front();
                checks++; if (tx_v[i] !== e) begin errors++; $display("FAIL parity_tx inst=%0d cycle=%0d got=%b exp=%b", i, c, tx_v[i], e); end
                checks++; if (done_v[i] !== (c == 44)) begin errors++; $display("FAIL parity_done inst=%0d cycle=%0d got=%b exp=%b", i, c, done_v[i], (c == 44)); end
                // Parity bit occupies cycles 37..40: 1 for even, 0 for odd on 0x07.
                if (c >= 37 && c <= 40) begin
                    checks++; if (tx_v[i] !== (i == 1)) begin errors++; $display("FAIL parity_bit inst=%0d cycle=%0d got=%b exp=%b", i, c, tx_v[i], (i == 1)); end
                end
            end
            @(negedge clk);
            checks++; if (busy_v[i] !== 1'b0) begin errors++; $display("FAIL parity_idle_busy inst=%0d got=%b exp=0", i, busy_v[i]); end
        end
    endtask

    task automatic test_back_to_back;
        logic e;
        @(negedge clk);
        din = 8'h01; valid_v[0] = 1'b1;
        push_frame(8'h01, 4, 0, 0, 1);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            din = 8'h02;
            e = exp_q.pop_front();
            checks++; if (tx_v[0] !== e) begin errors++; $display("FAIL b2b_tx1 cycle=%0d got=%b exp=%b", c, tx_v[0], e); end
            checks++; if (rdy_v[0] !== 1'b0) begin errors++; $display("FAIL b2b_ready1 cycle=%0d got=%b exp=0", c, rdy_v[0]); end
            checks++; if (done_v[0] !== (c == 40)) begin errors++; $display("FAIL b2b_done1 cycle=%0d got=%b exp=%b", c, done_v[0], (c == 40)); end
        end
        // The single idle gap: line high, ready up, valid still held.
        @(negedge clk);
        checks++; if ({tx_v[0], rdy_v[0], busy_v[0]} !== 3'b110) begin
            errors++; $display("FAIL b2b_gap got=%b exp=110", {tx_v[0], rdy_v[0], busy_v[0]}); end
        push_frame(8'h02, 4, 0, 0, 1);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            valid_v[0] = 1'b0;
            e = exp_q.pop_front();
            checks++; if (tx_v[0] !== e) begin errors++; $display("FAIL b2b_tx2 cycle=%0d got=%b exp=%b", c, tx_v[0], e); end
            checks++; if (rdy_v[0] !== 1'b0) begin errors++; $display("FAIL b2b_ready2 cycle=%0d got=%b exp=0", c, rdy_v[0]); end
            checks++; if (done_v[0] !== (c == 40)) begin errors++; $display("FAIL b2b_done2 cycle=%0d got=%b exp=%b", c, done_v[0], (c == 40)); end
        end
        @(negedge clk);
    endtask

    task automatic test_data_stability;
        logic e;
        @(negedge clk);
        din = 8'h3C; valid_v[0] = 1'b1;
        push_frame(8'h3C, 4, 0, 0, 1);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            valid_v[0] = 1'b0;
            din = 8'($urandom);
            e = exp_q.pop_front();
            checks++; if (tx_v[0] !== e) begin errors++; $display("FAIL stable_tx cycle=%0d got=%b exp=%b", c, tx_v[0], e); end
        end
        @(negedge clk);
    endtask

    task automatic test_div1;
        logic e;
        @(negedge clk);
        din = 8'hFF; valid_v[3] = 1'b1;
        push_frame(8'hFF, 1, 0, 0, 2);
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            valid_v[3] = 1'b0;
            e = exp_q.pop_front();
            checks++; if (tx_v[3] !== e) begin errors++; $display("FAIL div1_tx cycle=%0d got=%b exp=%b", c, tx_v[3], e); end
            checks++; if (done_v[3] !== (c == 11)) begin errors++; $display("FAIL div1_done cycle=%0d got=%b exp=%b", c, done_v[3], (c == 11)); end
            checks++; if (busy_v[3] !== 1'b1) begin errors++; $display("FAIL div1_busy cycle=%0d got=%b exp=1", c, busy_v[3]); end
        end
        @(negedge clk);
        checks++; if ({tx_v[3], busy_v[3], rdy_v[3]} !== 3'b101) begin
            errors++; $display("FAIL div1_idle got=%b exp=101", {tx_v[3], busy_v[3], rdy_v[3]}); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        din = 8'hA5; valid_v[0] = 1'b1;
        push_frame(8'hA5, 4, 0, 0, 1);
        // Cycle 12 is the second data bit (0) of 0xA5.
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            valid_v[0] = 1'b0;
            void'(exp_q.pop_front());
        end
        checks++; if (tx_v[0] !== 1'b0 || busy_v[0] !== 1'b1) begin
            errors++; $display("FAIL rstmid_pre got=%b%b exp=01", tx_v[0], busy_v[0]); end
        #2 rst = 1'b1;
        #1;
        exp_q.delete();
        checks++; if ({tx_v[0], busy_v[0], done_v[0], rdy_v[0]} !== 4'b1000) begin
            errors++; $display("FAIL rstmid_async got=%b exp=1000", {tx_v[0], busy_v[0], done_v[0], rdy_v[0]}); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (rdy_v[0] !== 1'b1) begin errors++; $display("FAIL rstmid_ready got=%b exp=1", rdy_v[0]); end
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            checks++; if ({tx_v[0], busy_v[0], done_v[0]} !== 3'b100) begin
                errors++; $display("FAIL rstmid_after cycle=%0d got=%b exp=100", c, {tx_v[0], busy_v[0], done_v[0]}); end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_basic();
        test_parity();
        test_back_to_back();
        test_data_stability();
        test_div1();
        test_reset_mid();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
